ff_bank_ctrl: RTL and testbench

Round-robin command controller that shares one bank of NREG × WIDTH flip-flop registers between NREQ requesters. Each accepted command applies a JK-style bitwise operation (hold, clear, set or toggle under a mask) to one register. The controller serialises access so exactly one register write happens per granted command. It sits between software- or FSM-driven requesters and the shared flag/state register bank.

---
 rtl/ff_ctrl_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/ff_bank_ctrl.sv | 94 +++++++++
 tb/tb_ff_bank_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ff_ctrl_pkg.sv
// Shared types and the masked JK-style register update for the flip-flop bank controller.
package ff_ctrl_pkg;

  typedef enum logic [1:0] {HOLD = 2'b00, CLR = 2'b01, SET = 2'b10, TOG = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE, EXEC, ACK} state_e;

  // Widest register the update helper handles; callers zero-extend and truncate.
  localparam int MAXW = 64;

  function automatic logic [MAXW-1:0] apply_op(op_e o, logic [MAXW-1:0] q, logic [MAXW-1:0] m);
    case (o)
      CLR:     return q & ~m;
      SET:     return q | m;
      TOG:     return q ^ m;
      default: return q;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority pick: lowest requester index at or above ptr wins, wrapping.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   win
);
  int            s;
  logic [PW-1:0] idx;

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    gnt = '0;
    win = '0;
    s   = 0;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      s = int'(ptr) + i;
      if (s >= NREQ) s = s - NREQ;
      idx = PW'(s);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        win      = idx;
      end
    end
  end

endmodule

// File: rtl/ff_bank_ctrl.sv
// Round-robin command controller serialising masked HOLD/CLR/SET/TOG writes into a shared register bank.
module ff_bank_ctrl
  import ff_ctrl_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int NREG  = 8,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       op,
  input  logic [AW*NREQ-1:0]      addr,
  input  logic [WIDTH*NREQ-1:0]   mask,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         ack,
  output logic                    busy,
  output logic [NREG*WIDTH-1:0]   q
);
  localparam int PW = $clog2(NREQ);

  state_e             state, state_d;
  logic [PW-1:0]      ptr, win, arb_win;
  logic [NREQ-1:0]    arb_gnt, gnt_d, ack_d;
  op_e                op_l;
  logic [AW-1:0]      addr_l;
  logic [WIDTH-1:0]   mask_l;
  logic [WIDTH-1:0]   bank [NREG];

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .win (arb_win)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_d;

  always_comb begin
    state_d = state;
    gnt_d   = '0;
    ack_d   = '0;
    unique case (state)
      IDLE: if (|req) begin
        state_d = EXEC;
        gnt_d   = arb_gnt;
      end
      EXEC: begin
        state_d = ACK;
        ack_d   = NREQ'(1) << win;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latch and registered handshake outputs; requests only sampled in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      win    <= '0;
      op_l   <= HOLD;
      addr_l <= '0;
      mask_l <= '0;
      gnt    <= '0;
      ack    <= '0;
      busy   <= 1'b0;
    end else begin
      gnt  <= gnt_d;
      ack  <= ack_d;
      busy <= (state_d != IDLE);
      if (state == IDLE && |req) begin
        win    <= arb_win;
        op_l   <= op_e'(op[2*arb_win +: 2]);
        addr_l <= addr[AW*arb_win +: AW];
        mask_l <= mask[WIDTH*arb_win +: WIDTH];
        ptr    <= (arb_win == PW'(NREQ - 1)) ? '0 : arb_win + PW'(1);
      end
    end
  end

  // Out-of-range addresses match no register, so they complete without a write.
  for (genvar r = 0; r < NREG; r++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
        bank[r] <= '0;
      else if (state == EXEC && addr_l == AW'(r))
        bank[r] <= WIDTH'(apply_op(op_l, MAXW'(bank[r]), MAXW'(mask_l)));
    assign q[WIDTH*r +: WIDTH] = bank[r];
  end

endmodule

// File: tb/tb_ff_bank_ctrl.sv
// Directed plus randomized checks of ff_bank_ctrl against a transaction-level bank/arbiter model.
module tb_ff_bank_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0, gnt, ack;
  logic [7:0]  op = '0;
  logic [11:0] addr = '0;
  logic [31:0] mask = '0;
  logic        busy;
  logic [63:0] q;

  logic [3:0]  req6 = '0, gnt6, ack6;
  logic [7:0]  op6 = '0;
  logic [11:0] addr6 = '0;
  logic [31:0] mask6 = '0;
  logic        busy6;
  logic [47:0] q6;

  int errors = 0;
  int checks = 0;

  logic [1:0] t_op   [4];
  logic [2:0] t_addr [4];
  logic [7:0] t_mask [4];
  logic [7:0] mdl    [8];
  int         ptr_m;

  ff_bank_ctrl #(.NREQ(4), .NREG(8), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .addr(addr), .mask(mask),
    .gnt(gnt), .ack(ack), .busy(busy), .q(q)
  );

  ff_bank_ctrl #(.NREQ(4), .NREG(6), .WIDTH(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .req(req6), .op(op6), .addr(addr6), .mask(mask6),
    .gnt(gnt6), .ack(ack6), .busy(busy6), .q(q6)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] jk(input logic [1:0] o, input logic [7:0] v, input logic [7:0] m);
    case (o)
      2'd1:    return v & ~m;
      2'd2:    return v | m;
      2'd3:    return v ^ m;
      default: return v;
    endcase
  endfunction

  function automatic logic [63:0] flat();
    logic [63:0] f;
    for (int r = 0; r < 8; r++) f[8*r +: 8] = mdl[r];
    return f;
  endfunction

  function automatic int pick(input logic [3:0] rq);
    for (int k = 0; k < 4; k++)
      if (rq[(ptr_m + k) % 4]) return (ptr_m + k) % 4;
    return -1;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 8; r++) mdl[r] = '0;
    ptr_m = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    tick();
    rst_n = 1'b1;
    clear_model();
  endtask

  // One arbitrated command: grant, write+ack, back to idle.
  task automatic step(input logic [3:0] rq, input bit drop_early);
    int w;
    for (int i = 0; i < 4; i++) begin
      op[2*i +: 2]   = t_op[i];
      addr[3*i +: 3] = t_addr[i];
      mask[8*i +: 8] = t_mask[i];
    end
    req = rq;
    w   = pick(rq);
    tick();
    chk("gnt", gnt, 64'(4'b1 << w));
    chk("busy_exec", busy, 1);
    chk("ack_in_exec", ack, 0);
    if (drop_early) req = '0;
    tick();
    mdl[t_addr[w]] = jk(t_op[w], mdl[t_addr[w]], t_mask[w]);
    chk("ack", ack, 64'(4'b1 << w));
    chk("gnt_in_ack", gnt, 0);
    chk("bank", q, flat());
    req   = '0;
    ptr_m = (w + 1) % 4;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_ack", ack, 0);
  endtask

  initial begin
    logic [3:0] rq;
    for (int i = 0; i < 4; i++) begin
      t_op[i] = '0; t_addr[i] = '0; t_mask[i] = '0;
    end
    clear_model();
    tick();
    tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_q", q, 0);
    chk("rst_q6", q6, 0);
    rst_n = 1'b1;

    // Basic SET, then TOG / CLR / HOLD from requester 1 on the same register.
    t_op[0] = 2'd2; t_addr[0] = 3'd3; t_mask[0] = 8'hA5;
    step(4'b0001, 0);
    chk("q3_set", q[31:24], 8'hA5);
    t_op[1] = 2'd3; t_addr[1] = 3'd3; t_mask[1] = 8'hFF;
    step(4'b0010, 0);
    chk("q3_tog", q[31:24], 8'h5A);
    t_op[1] = 2'd1; t_mask[1] = 8'h0F;
    step(4'b0010, 0);
    chk("q3_clr", q[31:24], 8'h50);
    t_op[1] = 2'd0; t_mask[1] = 8'hFF;
    step(4'b0010, 0);
    chk("q3_hold", q[31:24], 8'h50);

    // NREG=6 bank: valid write, then out-of-range address acked without a write.
    op6[1:0] = 2'd2; addr6[2:0] = 3'd5; mask6[7:0] = 8'h3C; req6 = 4'b0001;
    tick();
    chk("g6_gnt", gnt6, 4'b0001);
    tick();
    chk("g6_ack", ack6, 4'b0001);
    chk("g6_q", q6, 48'h3C00_0000_0000);
    req6 = '0;
    tick();
    op6[1:0] = 2'd3; addr6[2:0] = 3'd7; mask6[7:0] = 8'hFF; req6 = 4'b0001;
    tick();
    chk("g6_oor_gnt", gnt6, 4'b0001);
    tick();
    chk("g6_oor_ack", ack6, 4'b0001);
    chk("g6_oor_q", q6, 48'h3C00_0000_0000);
    req6 = '0;
    tick();

    // Continuous requests from all four: grants every 3 cycles in order 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      t_op[i] = 2'd2; t_addr[i] = 3'(i); t_mask[i] = 8'($urandom_range(1, 255));
      op[2*i +: 2] = t_op[i]; addr[3*i +: 3] = t_addr[i]; mask[8*i +: 8] = t_mask[i];
    end
    req = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      tick();
      chk($sformatf("rr_gnt_c%0d", c), gnt, (c % 3 == 0) ? 64'(4'b1 << ((c / 3) % 4)) : 64'd0);
      chk($sformatf("rr_ack_c%0d", c), ack, (c % 3 == 1) ? 64'(4'b1 << ((c / 3) % 4)) : 64'd0);
      if (c == 14) req = '0;
    end
    for (int i = 0; i < 4; i++) mdl[i] = t_mask[i];
    ptr_m = 1;
    tick();
    chk("rr_bank", q, flat());
    chk("rr_idle", busy, 0);

    // Reset during EXEC aborts the write; the still-held request is granted afresh.
    t_op[2] = 2'd2; t_addr[2] = 3'd2; t_mask[2] = 8'h77;
    op[5:4] = t_op[2]; addr[8:6] = t_addr[2]; mask[23:16] = t_mask[2];
    req = 4'b0100;
    tick();
    chk("mid_gnt", gnt, 4'b0100);
    rst_n = 1'b0;
    #1;
    clear_model();
    chk("mid_rst_q", q, 0);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_busy", busy, 0);
    tick();
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_q2", q, 0);
    rst_n = 1'b1;
    step(4'b0100, 0);

    // Request dropped right after grant still completes.
    t_op[3] = 2'd3; t_addr[3] = 3'd6; t_mask[3] = 8'hC3;
    step(4'b1000, 1);

    // Randomized contention against the model.
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 4; i++) begin
        t_op[i]   = 2'($urandom);
        t_addr[i] = 3'($urandom);
        t_mask[i] = 8'($urandom);
      end
      rq = 4'($urandom_range(1, 15));
      step(rq, bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
